// File: rtl/tdm2_demux_pkg.sv
// Shared definitions for the 2:1 TDM receive path: FSM state encoding and default slot width.
package tdm2_demux_pkg;
    localparam int TDM_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;
endpackage

// File: rtl/tdm_frame_counter.sv
// Bit-position counter for a 2-slot frame.
// It advances only on en cycles and can be restarted so that the current bit is position 0.
module tdm_frame_counter
    import tdm2_demux_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int CW    = $clog2(2*WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic pos0,
    output logic slot_a_end,
    output logic slot_b_end
);
    logic [CW-1:0] bcnt_q, bcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        if (en) begin
            // A restart marks the current bit as position 0, so the next bit is position 1.
            if (restart)
                bcnt_d = CW'(1);
            else if (bcnt_q == CW'(2*WIDTH-1))
                bcnt_d = '0;
            else
                bcnt_d = bcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bcnt_q <= '0;
        else     bcnt_q <= bcnt_d;
    end

    assign pos0       = (bcnt_q == '0);
    assign slot_a_end = (bcnt_q == CW'(WIDTH-1));
    assign slot_b_end = (bcnt_q == CW'(2*WIDTH-1));
endmodule

// File: rtl/tdm2_demux.sv
// 2:1 TDM receiver: acquires frame sync, holds lock, and delivers slot A/B words.
// Each delivered word is marked with a one-cycle valid pulse.
module tdm2_demux
    import tdm2_demux_pkg::*;
#(
    parameter int WIDTH       = TDM_WIDTH,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             fsync,
    input  logic             en,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             valid_a,
    output logic             valid_b,
    output logic             locked,
    output logic             sync_err
);
    localparam int GW = $clog2(LOCK_FRAMES+1);

    state_e           state_q, state_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [WIDTH-1:0] word_q, word_d, shifted;
    logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic             locked_q, locked_d, sync_err_q, sync_err_d;
    logic             detect, err;
    logic             pos0, slot_a_end, slot_b_end;

    tdm_frame_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .restart    (detect),
        .pos0       (pos0),
        .slot_a_end (slot_a_end),
        .slot_b_end (slot_b_end)
    );

    assign shifted = {word_q[WIDTH-2:0], din};

    always_comb begin
        state_d    = state_q;
        gcnt_d     = gcnt_q;
        word_d     = word_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        valid_a_d  = 1'b0;
        valid_b_d  = 1'b0;
        sync_err_d = 1'b0;
        locked_d   = locked_q;
        detect     = 1'b0;
        err        = 1'b0;
        if (en) begin
            word_d = shifted;
            case (state_q)
                ST_HUNT:
                    if (fsync) detect = 1'b1;
                ST_ACQ:
                    if (pos0) begin
                        if (!fsync)
                            state_d = ST_HUNT;
                        else if (gcnt_q + GW'(1) >= GW'(LOCK_FRAMES))
                            state_d = ST_LOCKED;
                        else
                            gcnt_d = gcnt_q + GW'(1);
                    end else if (fsync) begin
                        detect = 1'b1;
                    end
                ST_LOCKED: begin
                    err = pos0 ? !fsync : fsync;
                    if (err) begin
                        sync_err_d = 1'b1;
                        if (fsync) detect  = 1'b1;
                        else       state_d = ST_HUNT;
                    end else if (slot_a_end) begin
                        out_a_d   = shifted;
                        valid_a_d = 1'b1;
                    end else if (slot_b_end) begin
                        out_b_d   = shifted;
                        valid_b_d = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
            // Any fresh fsync detection (hunt or misplaced) restarts acquisition on this bit.
            if (detect) begin
                gcnt_d  = GW'(1);
                state_d = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_ACQ;
            end
            locked_d = (state_d == ST_LOCKED) && !err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            gcnt_q     <= '0;
            word_q     <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            word_q     <= word_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign out_a    = out_a_q;
    assign out_b    = out_b_q;
    assign valid_a  = valid_a_q;
    assign valid_b  = valid_b_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;
endmodule
